imm_rotate_encoder: RTL and testbench

//  Inverse of the operand-2 rotate path: takes a 32-bit constant and searches for an ARM

---
 rtl/imm_rotate_encoder_pkg.sv | 22 ++
 rtl/imm_rotate_encoder_if.sv | 28 ++
 rtl/imm_rot_check.sv | 25 ++
 rtl/imm_rotate_encoder.sv | 145 ++++++++++++++
 tb/tb_imm_rotate_encoder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_rotate_encoder_pkg.sv
// Shared types and constants for the rotated-immediate encoder.
// The encoder searches for imm8/rot4 such that value == ROR(imm8, 2*rot).
package imm_rotate_encoder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam int unsigned ROT_STEPS = 16;
    localparam int unsigned IMM_W     = 8;
    localparam int unsigned ROT_W     = 4;

    // One bit per permitted CHECKS_PER_CYCLE value: 1, 2, 4, 8, 16.
    localparam logic [16:0] CPC_LEGAL_MASK = 17'b1_0000_0001_0001_0110;

    function automatic logic cpc_legal(input int unsigned cpc);
        return (cpc <= 16) && CPC_LEGAL_MASK[cpc[4:0]];
    endfunction

endpackage

// File: rtl/imm_rotate_encoder_if.sv
// Request/response handshake bundle for imm_rotate_encoder.
// master = requester/consumer side, slave = encoder side.
interface imm_rotate_encoder_if;
    import imm_rotate_encoder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_value;
    logic             in_carry;
    logic             cancel;
    logic             out_valid;
    logic             out_ready;
    logic             out_encodable;
    logic [IMM_W-1:0] out_imm8;
    logic [ROT_W-1:0] out_rot;
    logic             out_carry;

    modport master (
        output in_valid, in_value, in_carry, cancel, out_ready,
        input  in_ready, out_valid, out_encodable, out_imm8, out_rot, out_carry
    );

    modport slave (
        input  in_valid, in_value, in_carry, cancel, out_ready,
        output in_ready, out_valid, out_encodable, out_imm8, out_rot, out_carry
    );

endinterface

// File: rtl/imm_rot_check.sv
// Tests one candidate rotation: value is encodable at rot iff ROL(value, 2*rot)
// fits in the low 8 bits, which then form imm8.
module imm_rot_check
    import imm_rotate_encoder_pkg::*;
(
    input  logic [31:0]      value,
    input  logic [ROT_W-1:0] rot,
    output logic             match,
    output logic [IMM_W-1:0] imm8
);

    logic [63:0] dbl;
    logic [5:0]  shamt;
    logic [31:0] rolled;

    // ROL by k is the 32-bit window of {value, value} starting at bit 32-k.
    always_comb begin
        dbl    = {value, value};
        shamt  = 6'd32 - {1'b0, rot, 1'b0};
        rolled = dbl[shamt +: 32];
        match  = (rolled[31:8] == 24'd0);
        imm8   = rolled[7:0];
    end

endmodule

// File: rtl/imm_rotate_encoder.sv
// Iterative search for the canonical ARM rotated-immediate encoding of a 32-bit
// constant, testing CHECKS_PER_CYCLE rotations per clock.
module imm_rotate_encoder
    import imm_rotate_encoder_pkg::*;
#(
    parameter int unsigned CHECKS_PER_CYCLE = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    imm_rotate_encoder_if.slave bus
);

    if (!cpc_legal(CHECKS_PER_CYCLE)) begin : g_bad_cpc
        $error("CHECKS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_e           state_q, state_d;
    logic [31:0]      value_q, value_d;
    logic             carry_q, carry_d;
    logic [4:0]       rot_cnt_q, rot_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             enc_q, enc_d;
    logic [IMM_W-1:0] imm8_q, imm8_d;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic             out_carry_q, out_carry_d;

    logic [CHECKS_PER_CYCLE-1:0] hit;
    logic [IMM_W-1:0]            hit_imm [CHECKS_PER_CYCLE];

    for (genvar g = 0; g < CHECKS_PER_CYCLE; g++) begin : g_check
        logic [ROT_W-1:0] rot_g;
        assign rot_g = rot_cnt_q[ROT_W-1:0] + ROT_W'(g);

        imm_rot_check u_check (
            .value (value_q),
            .rot   (rot_g),
            .match (hit[g]),
            .imm8  (hit_imm[g])
        );
    end

    logic             sel_found;
    logic [IMM_W-1:0] sel_imm;
    logic [ROT_W-1:0] sel_rot;

    // Descending scan so the lowest matching rotation is the one left selected.
    always_comb begin
        sel_found = 1'b0;
        sel_imm   = '0;
        sel_rot   = '0;
        for (int i = int'(CHECKS_PER_CYCLE) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_found = 1'b1;
                sel_imm   = hit_imm[i];
                sel_rot   = rot_cnt_q[ROT_W-1:0] + ROT_W'(i);
            end
        end
    end

    logic [4:0] rot_cnt_nxt;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        carry_d     = carry_q;
        rot_cnt_d   = rot_cnt_q;
        out_valid_d = out_valid_q;
        enc_d       = enc_q;
        imm8_d      = imm8_q;
        rot_d       = rot_q;
        out_carry_d = out_carry_q;
        rot_cnt_nxt = rot_cnt_q + 5'(CHECKS_PER_CYCLE);

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    value_d   = bus.in_value;
                    carry_d   = bus.in_carry;
                    rot_cnt_d = '0;
                    state_d   = StSearch;
                end
            end
            StSearch: begin
                if (bus.cancel) begin
                    state_d = StIdle;
                end else if (sel_found) begin
                    enc_d       = 1'b1;
                    imm8_d      = sel_imm;
                    rot_d       = sel_rot;
                    out_carry_d = (sel_rot == '0) ? carry_q : value_q[31];
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else if (rot_cnt_nxt == 5'(ROT_STEPS)) begin
                    enc_d       = 1'b0;
                    imm8_d      = '0;
                    rot_d       = '0;
                    out_carry_d = carry_q;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    rot_cnt_d = rot_cnt_nxt;
                end
            end
            StDone: begin
                if (bus.cancel || bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            value_q     <= '0;
            carry_q     <= 1'b0;
            rot_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            enc_q       <= 1'b0;
            imm8_q      <= '0;
            rot_q       <= '0;
            out_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            carry_q     <= carry_d;
            rot_cnt_q   <= rot_cnt_d;
            out_valid_q <= out_valid_d;
            enc_q       <= enc_d;
            imm8_q      <= imm8_d;
            rot_q       <= rot_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign bus.in_ready      = (state_q == StIdle);
    assign bus.out_valid     = out_valid_q;
    assign bus.out_encodable = enc_q;
    assign bus.out_imm8      = imm8_q;
    assign bus.out_rot       = rot_q;
    assign bus.out_carry     = out_carry_q;

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Self-checking bench for imm_rotate_encoder: directed cases plus random constants
// checked against a brute-force encoding search, on CHECKS_PER_CYCLE = 1 and 4.
module tb_imm_rotate_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    imm_rotate_encoder_if bus0 ();
    imm_rotate_encoder_if bus4 ();

    imm_rotate_encoder #(.CHECKS_PER_CYCLE(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    imm_rotate_encoder #(.CHECKS_PER_CYCLE(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror32(input logic [31:0] v, input int sh);
        if (sh == 0) return v;
        return (v >> sh) | (v << (32 - sh));
    endfunction

    // Brute force over every (rot, imm8) pair; lowest rot that reproduces v wins.
    task automatic ref_encode(input logic [31:0] v, input bit c, output bit enc,
                              output logic [7:0] imm, output logic [3:0] rot,
                              output bit car, output int r_hit);
        enc = 0; imm = 0; rot = 0; car = c; r_hit = -1;
        for (int r = 0; r < 16 && !enc; r++) begin
            for (int k = 0; k < 256 && !enc; k++) begin
                if (ror32(32'(k), 2 * r) == v) begin
                    enc = 1; imm = 8'(k); rot = 4'(r); r_hit = r;
                    car = (r == 0) ? c : v[31];
                end
            end
        end
    endtask

    task automatic run_req(input logic [31:0] v, input bit c, input int hold, input bit poke);
        bit enc, car; logic [7:0] imm; logic [3:0] rot; int r_hit, exp_lat, lat;
        ref_encode(v, c, enc, imm, rot, car, r_hit);
        exp_lat = enc ? r_hit + 1 : 16;
        n_checks++;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL in_ready_idle v=%h got=%b exp=1", v, bus0.in_ready);
        end
        bus0.in_valid = 1; bus0.in_value = v; bus0.in_carry = c;
        @(posedge clk); #1;
        bus0.in_valid = 0; bus0.in_value = $urandom; bus0.in_carry = 1'($urandom);
        lat = 0;
        while (bus0.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        n_checks += 5;
        if (lat != exp_lat) begin
            n_fail++; $display("FAIL latency v=%h got=%0d exp=%0d", v, lat, exp_lat);
        end
        if (bus0.out_encodable !== enc) begin
            n_fail++; $display("FAIL encodable v=%h got=%b exp=%b", v, bus0.out_encodable, enc);
        end
        if (bus0.out_imm8 !== imm) begin
            n_fail++; $display("FAIL imm8 v=%h got=%h exp=%h", v, bus0.out_imm8, imm);
        end
        if (bus0.out_rot !== rot) begin
            n_fail++; $display("FAIL rot v=%h got=%0d exp=%0d", v, bus0.out_rot, rot);
        end
        if (bus0.out_carry !== car) begin
            n_fail++; $display("FAIL carry v=%h got=%b exp=%b", v, bus0.out_carry, car);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0 || bus0.out_imm8 !== imm ||
                bus0.out_rot !== rot || bus0.out_encodable !== enc || bus0.out_carry !== car) begin
                n_fail++;
                $display("FAIL hold_stable v=%h cyc=%0d got vld=%b rdy=%b imm=%h rot=%0d exp vld=1 rdy=0 imm=%h rot=%0d",
                         v, h, bus0.out_valid, bus0.in_ready, bus0.out_imm8, bus0.out_rot, imm, rot);
            end
            if (poke) begin
                bus0.in_valid = 1'(h & 1); bus0.in_value = $urandom;
            end
        end
        bus0.in_valid = 0;
        bus0.out_ready = 1;
        @(posedge clk); #1;
        bus0.out_ready = 0;
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release v=%h got vld=%b rdy=%b exp vld=0 rdy=1",
                               v, bus0.out_valid, bus0.in_ready);
        end
    endtask

    task automatic run_req4(input logic [31:0] v, input bit c);
        bit enc, car; logic [7:0] imm; logic [3:0] rot; int r_hit, exp_lat, lat;
        ref_encode(v, c, enc, imm, rot, car, r_hit);
        exp_lat = enc ? r_hit / 4 + 1 : 4;
        bus4.in_valid = 1; bus4.in_value = v; bus4.in_carry = c;
        @(posedge clk); #1;
        bus4.in_valid = 0; bus4.in_value = $urandom;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (lat != exp_lat || bus4.out_encodable !== enc || bus4.out_imm8 !== imm ||
            bus4.out_rot !== rot || bus4.out_carry !== car) begin
            n_fail++;
            $display("FAIL cpc4 v=%h got lat=%0d enc=%b imm=%h rot=%0d c=%b exp lat=%0d enc=%b imm=%h rot=%0d c=%b",
                     v, lat, bus4.out_encodable, bus4.out_imm8, bus4.out_rot, bus4.out_carry,
                     exp_lat, enc, imm, rot, car);
        end
        bus4.out_ready = 1;
        @(posedge clk); #1;
        bus4.out_ready = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks += 2;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.out_encodable !== 1'b0 ||
            bus0.out_imm8 !== 8'h0 || bus0.out_rot !== 4'h0 || bus0.out_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dut0 got rdy=%b vld=%b enc=%b imm=%h rot=%0d c=%b exp 1 0 0 00 0 0", tag,
                     bus0.in_ready, bus0.out_valid, bus0.out_encodable, bus0.out_imm8, bus0.out_rot,
                     bus0.out_carry);
        end
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.out_imm8 !== 8'h0) begin
            n_fail++;
            $display("FAIL %s dut4 got rdy=%b vld=%b imm=%h exp 1 0 00", tag,
                     bus4.in_ready, bus4.out_valid, bus4.out_imm8);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1;
        @(posedge clk); #1;
        check_reset_outputs("after_release");
    endtask

    task automatic test_directed();
        run_req(32'h0000_00FF, 1'b1, 0, 1'b0);
        run_req(32'hF000_000F, 1'b0, 0, 1'b0);
        run_req(32'h0000_0102, 1'b1, 0, 1'b0);
        run_req(32'h0000_0102, 1'b0, 0, 1'b0);
        run_req(32'h0000_0000, 1'b1, 0, 1'b0);
        run_req(32'hFF00_0000, 1'b0, 10, 1'b1);
        n_checks++;
        @(posedge clk); #1;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ignored_in_valid got vld=%b rdy=%b exp vld=0 rdy=1",
                               bus0.out_valid, bus0.in_ready);
        end
    endtask

    task automatic test_cancel();
        bit seen;
        bus0.in_valid = 1; bus0.in_value = 32'h0000_0102; bus0.in_carry = 1;
        @(posedge clk); #1;
        bus0.in_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        bus0.cancel = 1;
        @(posedge clk); #1;
        bus0.cancel = 0;
        n_checks++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL cancel_search got rdy=%b vld=%b exp rdy=1 vld=0",
                               bus0.in_ready, bus0.out_valid);
        end
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus0.out_valid === 1'b1) seen = 1; end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL cancel_no_valid got out_valid=1 exp=0");
        end
        run_req(32'h0000_00FF, 1'b0, 0, 1'b0);
        // Cancel while DONE, together with out_ready: outputs must keep their values.
        bus0.in_valid = 1; bus0.in_value = 32'hFF00_0000; bus0.in_carry = 0;
        @(posedge clk); #1;
        bus0.in_valid = 0;
        repeat (5) begin @(posedge clk); #1; end
        bus0.cancel = 1; bus0.out_ready = 1;
        @(posedge clk); #1;
        bus0.cancel = 0; bus0.out_ready = 0;
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.out_imm8 !== 8'hFF ||
            bus0.out_rot !== 4'd4 || bus0.out_carry !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_done got vld=%b rdy=%b imm=%h rot=%0d c=%b exp 0 1 ff 4 1",
                     bus0.out_valid, bus0.in_ready, bus0.out_imm8, bus0.out_rot, bus0.out_carry);
        end
    endtask

    task automatic test_reset_mid();
        bus0.in_valid = 1; bus0.in_value = 32'h0000_0102; bus0.in_carry = 1;
        @(posedge clk); #1;
        bus0.in_valid = 0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 0;
        #1 check_reset_outputs("async_reset_mid");
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        run_req(32'hF000_000F, 1'b0, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
                1: v = $urandom;
                2: v = 32'($urandom_range(0, 3)) << $urandom_range(0, 31);
                default: v = ror32(32'($urandom_range(0, 1023)), int'($urandom_range(0, 31)));
            endcase
            run_req(v, 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    task automatic test_cpc4();
        logic [31:0] v;
        run_req4(32'h0000_0102, 1'b1);
        run_req4(32'hF000_000F, 1'b0);
        run_req4(32'h0000_00FF, 1'b1);
        for (int n = 0; n < 16; n++) begin
            v = ($urandom_range(0, 1) == 1) ? $urandom
                : ror32(32'($urandom_range(1, 255)), 2 * int'($urandom_range(0, 15)));
            run_req4(v, 1'($urandom));
        end
    endtask

    initial begin
        bus0.in_valid = 0; bus0.in_value = 0; bus0.in_carry = 0; bus0.cancel = 0;
        bus0.out_ready = 0;
        bus4.in_valid = 0; bus4.in_value = 0; bus4.in_carry = 0; bus4.cancel = 0;
        bus4.out_ready = 0;
        test_reset();
        test_directed();
        test_cancel();
        test_reset_mid();
        test_random();
        test_cpc4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
